// File: rtl/rvm_axi4_sram_slave_pkg.sv
// Shared AXI response codes and FSM state encodings for the AXI4 SRAM slave.
package rvm_axi4_sram_slave_pkg;

   localparam logic [1:0] RVM_AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] RVM_AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      RVM_SRAM_ST_IDLE       = 2'd0,
      RVM_SRAM_ST_RD_RESP    = 2'd1,
      RVM_SRAM_ST_WR_COLLECT = 2'd2,
      RVM_SRAM_ST_WR_RESP    = 2'd3
   } rvm_sram_state_e;

endpackage

// File: rtl/rvm_sram_1rw.sv
// Single-port word RAM: synchronous read, per-byte write enables.
// Read data is held until the next read enable.
module rvm_sram_1rw #(
   parameter int DEPTH     = 4096,
   parameter     INIT_FILE = ""
) (
   input  logic                     clk,
   input  logic                     re,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/rvm_axi4_sram_slave.sv
// AXI4 slave over a byte-enabled SRAM, one transaction at a time.
// RVALID 1 cycle after AR; write commits 1 cycle after last of AW/W, BVALID the cycle after.
// RVM_AXI_SRAM_RANGE_ERR_EN: out-of-window accesses return SLVERR instead of aliasing.
module rvm_axi4_sram_slave
   import rvm_axi4_sram_slave_pkg::*;
#(
   parameter int          MEM_DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter              MEM_INIT_FILE   = ""
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic [2:0]  S_AXI_ARSIZE,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic [2:0]  S_AXI_AWSIZE,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY
);

   localparam int          IDX_W = $clog2(MEM_DEPTH_WORDS);
   localparam logic [32:0] SPAN  = 33'(MEM_DEPTH_WORDS) << 2;

   rvm_sram_state_e state, state_nxt;

   logic             aw_got, w_got;
   logic [IDX_W-1:0] wr_idx;
   logic             wr_err;
   logic [31:0]      wr_data;
   logic [3:0]       wr_strb;
   logic             rd_err;

   logic             ar_fire, aw_fire, w_fire, commit;
   logic [IDX_W-1:0] ar_idx, aw_idx;
   logic             ar_err, aw_err;
   logic [31:0]      ram_rdata;
   logic [3:0]       ram_we;
   logic [IDX_W-1:0] ram_addr;

   logic unused_size;
   assign unused_size = ^{S_AXI_ARSIZE, S_AXI_AWSIZE};

   // Truncating the word offset to IDX_W bits is the modulo-depth wrap.
   assign ar_idx = IDX_W'((S_AXI_ARADDR - BASE_ADDR) >> 2);
   assign aw_idx = IDX_W'((S_AXI_AWADDR - BASE_ADDR) >> 2);

`ifdef RVM_AXI_SRAM_RANGE_ERR_EN
   // Addresses below BASE_ADDR wrap to a large offset and fail the same check.
   assign ar_err = ({1'b0, S_AXI_ARADDR - BASE_ADDR} >= SPAN);
   assign aw_err = ({1'b0, S_AXI_AWADDR - BASE_ADDR} >= SPAN);
`else
   assign ar_err = 1'b0;
   assign aw_err = 1'b0;
`endif

   assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
   assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_fire  = S_AXI_WVALID  && S_AXI_WREADY;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state  <= RVM_SRAM_ST_IDLE;
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         rd_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (aw_fire) aw_got <= 1'b1;
         if (w_fire)  w_got  <= 1'b1;
         if (commit) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (ar_fire) rd_err <= ar_err;
      end
   end

   always_ff @(posedge ACLK) begin
      if (aw_fire) begin
         wr_idx <= aw_idx;
         wr_err <= aw_err;
      end
      if (w_fire) begin
         wr_data <= S_AXI_WDATA;
         wr_strb <= S_AXI_WSTRB;
      end
   end

   always_comb begin
      state_nxt     = state;
      S_AXI_ARREADY = 1'b0;
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_RVALID  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      commit        = 1'b0;
      case (state)
         RVM_SRAM_ST_IDLE: begin
            S_AXI_ARREADY = 1'b1;
            S_AXI_AWREADY = !S_AXI_ARVALID;
            S_AXI_WREADY  = !S_AXI_ARVALID;
            if (S_AXI_ARVALID)
               state_nxt = RVM_SRAM_ST_RD_RESP;
            else if (S_AXI_AWVALID || S_AXI_WVALID)
               state_nxt = RVM_SRAM_ST_WR_COLLECT;
         end
         RVM_SRAM_ST_WR_COLLECT: begin
            S_AXI_AWREADY = !aw_got;
            S_AXI_WREADY  = !w_got;
            if (aw_got && w_got) begin
               commit    = 1'b1;
               state_nxt = RVM_SRAM_ST_WR_RESP;
            end
         end
         RVM_SRAM_ST_RD_RESP: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) state_nxt = RVM_SRAM_ST_IDLE;
         end
         RVM_SRAM_ST_WR_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) state_nxt = RVM_SRAM_ST_IDLE;
         end
         default: state_nxt = RVM_SRAM_ST_IDLE;
      endcase
      // Reset silences every output and blocks a pending commit in the same cycle.
      if (ARESET) begin
         S_AXI_ARREADY = 1'b0;
         S_AXI_AWREADY = 1'b0;
         S_AXI_WREADY  = 1'b0;
         S_AXI_RVALID  = 1'b0;
         S_AXI_BVALID  = 1'b0;
         commit        = 1'b0;
      end
   end

   assign ram_we   = (commit && !wr_err) ? wr_strb : 4'b0000;
   assign ram_addr = commit ? wr_idx : ar_idx;

   assign S_AXI_RDATA = (S_AXI_RVALID && !rd_err) ? ram_rdata : 32'h0;
   assign S_AXI_RRESP = (S_AXI_RVALID && rd_err) ? RVM_AXI_RESP_SLVERR : RVM_AXI_RESP_OKAY;
   assign S_AXI_BRESP = (S_AXI_BVALID && wr_err) ? RVM_AXI_RESP_SLVERR : RVM_AXI_RESP_OKAY;

   rvm_sram_1rw #(
      .DEPTH     (MEM_DEPTH_WORDS),
      .INIT_FILE (MEM_INIT_FILE)
   ) u_ram (
      .clk   (ACLK),
      .re    (ar_fire),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wr_data),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_rvm_axi4_sram_slave.sv
// Randomized bench for rvm_axi4_sram_slave against a word-array reference memory.
module tb_rvm_axi4_sram_slave;

   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARSIZE;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [31:0] S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWSIZE;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] model [DEPTH];

   always #5 ACLK = ~ACLK;

   rvm_axi4_sram_slave #(
      .MEM_DEPTH_WORDS (DEPTH),
      .BASE_ADDR       (BASE),
      .MEM_INIT_FILE   ("")
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARSIZE  (S_AXI_ARSIZE),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWSIZE  (S_AXI_AWSIZE),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY)
   );

   // Reference decode: plain arithmetic on the byte address.
   function automatic bit addr_ok(input logic [31:0] addr);
`ifdef RVM_AXI_SRAM_RANGE_ERR_EN
      longint off;
      off = longint'(addr) - longint'(BASE);
      return (off >= 0) && (off < 4 * longint'(DEPTH));
`else
      return (addr == addr) || 1'b1;
`endif
   endfunction

   function automatic int word_of(input logic [31:0] addr);
      longint off;
      off = (longint'(addr) - longint'(BASE)) & 64'hFFFF_FFFF;
      return int'((off / 4) % DEPTH);
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int w;
      if (!addr_ok(addr)) return;
      w = word_of(addr);
      for (int b = 0; b < 4; b++)
         if (strb[b]) model[w][8*b +: 8] = data[8*b +: 8];
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
      int  aw_at, w_at, t;
      bit  aw_done, w_done, aw_hs, w_hs;
      logic [1:0] exp_resp;
      aw_at = (lead > 0) ? lead : 0;
      w_at  = (lead < 0) ? -lead : 0;
      aw_done = 0; w_done = 0; t = 0;
      exp_resp = addr_ok(addr) ? 2'b00 : 2'b10;
      while (!(aw_done && w_done) && t < 20) begin
         @(negedge ACLK);
         S_AXI_AWADDR  = addr;
         S_AXI_WDATA   = data;
         S_AXI_WSTRB   = strb;
         S_AXI_AWVALID = !aw_done && (t >= aw_at);
         S_AXI_WVALID  = !w_done && (t >= w_at);
         #1;
         if (w_done && !aw_done) begin
            n_cmp++;
            if (S_AXI_WREADY !== 1'b0) begin
               n_fail++;
               $display("FAIL wready_after_w: got %b want 0", S_AXI_WREADY);
            end
         end
         if (aw_done && !w_done) begin
            n_cmp++;
            if (S_AXI_AWREADY !== 1'b0) begin
               n_fail++;
               $display("FAIL awready_after_aw: got %b want 0", S_AXI_AWREADY);
            end
         end
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge ACLK);
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done  = 1;
         t++;
      end
      @(negedge ACLK);
      S_AXI_AWVALID = 0;
      S_AXI_WVALID  = 0;
      n_cmp++;
      if (!(aw_done && w_done)) begin
         n_fail++;
         $display("FAIL write_handshake_timeout: aw=%0d w=%0d want both 1", aw_done, w_done);
         return;
      end
      #1;
      n_cmp++;
      if (S_AXI_BVALID !== 1'b0) begin
         n_fail++;
         $display("FAIL bvalid_commit_cycle: got %b want 0", S_AXI_BVALID);
      end
      model_write(addr, data, strb);
      @(negedge ACLK);
      S_AXI_BREADY = 1;
      #1;
      n_cmp++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp_resp) begin
         n_fail++;
         $display("FAIL b_response: got valid=%b resp=%b want 1/%b", S_AXI_BVALID, S_AXI_BRESP, exp_resp);
      end
      @(negedge ACLK);
      S_AXI_BREADY = 0;
      #1;
      n_cmp++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL b_done_idle: got bvalid=%b arready=%b want 0/1", S_AXI_BVALID, S_AXI_ARREADY);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input int stall);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      exp_d = addr_ok(addr) ? model[word_of(addr)] : 32'h0;
      exp_r = addr_ok(addr) ? 2'b00 : 2'b10;
      @(negedge ACLK);
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1;
      #1;
      n_cmp++;
      if (S_AXI_ARREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL arready_idle: got %b want 1", S_AXI_ARREADY);
      end
      @(negedge ACLK);
      // Keep a second AR pending during the stall; it must not be taken.
      S_AXI_ARVALID = (stall > 0);
      S_AXI_RREADY  = (stall == 0);
      #1;
      n_cmp++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_d || S_AXI_RRESP !== exp_r) begin
         n_fail++;
         $display("FAIL r_first_beat @%h: got v=%b d=%h r=%b want 1/%h/%b",
                  addr, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, exp_d, exp_r);
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge ACLK);
         if (i == stall - 1) begin
            S_AXI_ARVALID = 0;
            S_AXI_RREADY  = 1;
         end
         #1;
         n_cmp++;
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_d || S_AXI_RRESP !== exp_r
             || S_AXI_ARREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL r_stall_hold cyc%0d: got v=%b d=%h r=%b arrdy=%b want 1/%h/%b/0",
                     i, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY, exp_d, exp_r);
         end
      end
      @(negedge ACLK);
      S_AXI_RREADY = 0;
      #1;
      n_cmp++;
      if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL r_done_idle: got rvalid=%b arready=%b want 0/1", S_AXI_RVALID, S_AXI_ARREADY);
      end
   endtask

   task automatic test_reset;
      ARESET = 1;
      S_AXI_ARADDR = 0; S_AXI_ARSIZE = 3'b010; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
      S_AXI_AWADDR = 0; S_AXI_AWSIZE = 3'b010; S_AXI_AWVALID = 0;
      S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
      repeat (3) @(negedge ACLK);
      #1;
      n_cmp++;
      if ({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_RVALID, S_AXI_BVALID,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP} !== 41'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ar=%b aw=%b w=%b rv=%b bv=%b want all 0",
                  S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_RVALID, S_AXI_BVALID);
      end
      @(negedge ACLK);
      ARESET = 0;
      #1;
      n_cmp++;
      if (S_AXI_ARREADY !== 1'b1 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_after_reset: got ar=%b aw=%b w=%b want 1/1/1",
                  S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY);
      end
   endtask

   task automatic test_read_latency;
      axi_write(32'h40, 32'hDEADBEEF, 4'hF, 0);
      axi_read(32'h40, 0);
   endtask

   task automatic test_strobe;
      axi_write(32'h80, 32'hAAAAAAAA, 4'hF, 0);
      axi_write(32'h80, 32'h11223344, 4'b0101, 0);
      n_cmp++;
      if (model[word_of(32'h80)] !== 32'hAA22AA44) begin
         n_fail++;
         $display("FAIL strobe_model: got %h want aa22aa44", model[word_of(32'h80)]);
      end
      axi_read(32'h80, 0);
      axi_write(32'h80, 32'h55555555, 4'b0000, 0);
      axi_read(32'h80, 0);
   endtask

   task automatic test_channel_order;
      axi_write(32'h84, 32'hCAFEF00D, 4'hF, 3);
      axi_read(32'h84, 0);
      axi_write(32'h88, 32'h0BADF00D, 4'hF, -2);
      axi_read(32'h8B, 0);
   endtask

   task automatic test_priority;
      logic [31:0] newv;
      newv = 32'h5A5A1234;
      axi_write(32'hC0, 32'h01020304, 4'hF, 0);
      @(negedge ACLK);
      S_AXI_ARADDR = 32'hC0; S_AXI_ARVALID = 1;
      S_AXI_AWADDR = 32'hC0; S_AXI_AWVALID = 1;
      S_AXI_WDATA = newv; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      #1;
      n_cmp++;
      if ({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
         n_fail++;
         $display("FAIL priority_ready: got %b%b%b want 100", S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(negedge ACLK);
      S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
      #1;
      n_cmp++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h01020304 || S_AXI_AWREADY !== 1'b0) begin
         n_fail++;
         $display("FAIL priority_read_first: got v=%b d=%h awrdy=%b want 1/01020304/0",
                  S_AXI_RVALID, S_AXI_RDATA, S_AXI_AWREADY);
      end
      @(negedge ACLK);
      S_AXI_RREADY = 0;
      #1;
      n_cmp++;
      if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL priority_write_next: got aw=%b w=%b want 1/1", S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(negedge ACLK);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      model_write(32'hC0, newv, 4'hF);
      @(negedge ACLK);
      S_AXI_BREADY = 1;
      #1;
      n_cmp++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
         n_fail++;
         $display("FAIL priority_b: got v=%b r=%b want 1/00", S_AXI_BVALID, S_AXI_BRESP);
      end
      @(negedge ACLK);
      S_AXI_BREADY = 0;
      axi_read(32'hC0, 0);
   endtask

   task automatic test_rready_stall;
      axi_read(32'h84, 5);
   endtask

   task automatic test_reset_midwrite;
      axi_write(32'h90, 32'h13579BDF, 4'hF, 0);
      @(negedge ACLK);
      S_AXI_AWADDR = 32'h90; S_AXI_AWVALID = 1;
      @(negedge ACLK);
      S_AXI_AWVALID = 0;
      S_AXI_WDATA = 32'hFFFF0000; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      ARESET = 1;
      #1;
      n_cmp++;
      if ({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_RVALID, S_AXI_BVALID,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP} !== 41'h0) begin
         n_fail++;
         $display("FAIL midwrite_reset_outputs: got aw=%b w=%b bv=%b want 0/0/0",
                  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID);
      end
      @(negedge ACLK);
      ARESET = 0; S_AXI_WVALID = 0;
      #1;
      n_cmp++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL midwrite_reset_idle: got bv=%b ar=%b want 0/1", S_AXI_BVALID, S_AXI_ARREADY);
      end
      axi_read(32'h90, 0);
   endtask

   task automatic test_boundary;
      axi_write(BASE, 32'h00C0FFEE, 4'hF, 0);
      axi_write(BASE + 4 * DEPTH + 2, 32'h77665544, 4'b1100, 1);
      axi_read(BASE + 4 * DEPTH, 0);
      axi_read(BASE, 0);
      axi_read(BASE + 4 * (DEPTH - 1), 0);
   endtask

   task automatic test_random;
      logic [31:0] addr;
      for (int i = 0; i < 16; i++)
         axi_write(BASE + 32'h100 + 4 * i, $urandom, 4'hF, 0);
      for (int n = 0; n < 40; n++) begin
         addr = BASE + 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1)
            axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3);
         else
            axi_read(addr, $urandom_range(0, 3));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_latency();
      test_strobe();
      test_channel_order();
      test_priority();
      test_rready_stall();
      test_reset_midwrite();
      test_boundary();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
